uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  Serial (8N1 UART) program loader: receives a framed 16-byte image from the host over USB-UART
//  and writes it into the CPU's 16x8 program RAM through a single write port.
//  Holds the CPU (cpu_hold) while a frame is in flight. It is the writer of the RAM the CPU fetches from.
//  Frame: 0xA5 sync, 16 data bytes (addr 0..15), [checksum byte, see CONFIGURATION].
// PARAMETERS
//  CLK_HZ      24000000  system clock frequency, Hz
//  BAUD        115200    line rate; bit period DIV = CLK_HZ/BAUD truncated (208 at defaults)
//  DEPTH       16        program RAM words per frame; ADDR_W = $clog2(DEPTH)
//  TIMEOUT_CYC 2400000   max idle cycles between bytes inside a frame (100 ms)
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  rxd        in   1       UART receive line, idle high, asynchronous to clk
//  ram_we     out  1       one-cycle write strobe to program RAM
//  ram_addr   out  ADDR_W  write address
//  ram_wdata  out  8       write data
//  cpu_hold   out  1       high = CPU must not step (frame in progress)
//  busy       out  1       high whenever FSM is not in IDLE
//  load_done  out  1       one-cycle pulse: frame accepted
//  load_err   out  1       one-cycle pulse: frame aborted (framing, timeout, checksum)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; RX core idle. Reset mid-frame: hold released immediately;
//   RAM words already written stay written (no rollback).
//  RX core: rxd through 2-FF synchroniser. Falling edge in idle -> wait DIV/2, resample; if high,
//   false start, return to idle. Else sample 8 data bits LSB-first at DIV intervals, then stop bit.
//   Stop=1 -> byte_valid pulse (1 cycle) with byte; stop=0 -> frame_err pulse, no byte_valid.
//   After stop sample, core re-arms immediately (back-to-back bytes supported).
//  Loader FSM: IDLE -> DATA -> [CHK] -> IDLE.
//   IDLE: bytes != 0xA5 ignored; 0xA5 -> DATA, idx=0, sum=0, cpu_hold=1 next cycle.
//   DATA: each byte -> next cycle ram_we=1, ram_addr=idx, ram_wdata=byte; sum+=byte (mod 256);
//    idx==DEPTH-1 -> CHK (macro on) or IDLE with load_done pulse (macro off).
//   CHK: byte==sum -> load_done; else load_err. Either way -> IDLE.
//   ram_we latency: exactly 1 cycle after byte_valid. idx never wraps; a 0xA5 in DATA is data.
//  Aborts (from DATA/CHK): frame_err or gap counter reaching TIMEOUT_CYC -> load_err pulse, IDLE.
//   Gap counter clears on every byte_valid and on entry to DATA. frame_err in IDLE: ignored.
//  cpu_hold falls in the same cycle load_done/load_err pulses. load_done and load_err never coincide.
//  busy = (state != IDLE).
// CONFIGURATION
//  UART_LOADER_CHECKSUM_EN defined: trailing checksum byte required = 8-bit sum of 16 data bytes;
//   mismatch -> load_err (RAM already written; host must resend).
//  Undefined: no CHK state; load_done pulses the cycle after the 16th ram_we.
// STRUCTURE
//  Package loader_pkg: SYNC_BYTE=8'hA5, state enum {IDLE,DATA,CHK}, DIV/ADDR_W helper functions.
//  Sub-module uart_rx_core (synchroniser, bit timer, shift reg; outputs byte, byte_valid, frame_err);
//   uart_prog_loader instantiates it and holds the framing FSM, gap counter, checksum.
// TESTING
//  Good frame A5,00..0F(+sum 0x78) -> 16 ram_we, addr i data i, load_done once, hold low after.
//  Noise 3C,FF then good frame -> leading bytes ignored, frame loads normally.
//  Stop bit forced 0 on byte 5 -> load_err, FSM IDLE, addrs 0..4 written only, hold released.
//  Stall 120 ms after byte 7 -> load_err at TIMEOUT_CYC; next A5 frame loads cleanly.
//  (CHECKSUM_EN) bad checksum 0x00 -> load_err, no load_done; 16 writes still observed.
//  rst_n low mid-DATA -> outputs 0 asynchronously, hold low; new frame after release loads.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared constants, loader state encoding and sizing helpers for the UART program loader
package loader_pkg;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   typedef enum logic [1:0] {IDLE, DATA, CHK} state_t;
   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction
   function automatic int calc_addr_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 receiver with 2-FF synchroniser, mid-bit sampling and false-start rejection
module uart_rx_core #(
   parameter int DIV = 208
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err
);
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DIV - 1);
   logic [1:0]       sync;
   logic             prev, active;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       n;
   logic [7:0]       sh;
   // bit timer: n=0 start check, 1..8 data LSB first, 9 stop; idles again right after the stop sample
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync       <= 2'b11;
         prev       <= 1'b1;
         active     <= 1'b0;
         cnt        <= '0;
         n          <= '0;
         sh         <= '0;
         data       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync       <= {sync[0], rxd};
         prev       <= sync[1];
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (!active) begin
            if (prev && !sync[1]) begin
               active <= 1'b1;
               cnt    <= HALF;
               n      <= '0;
            end
         end else if (cnt != '0)
            cnt <= cnt - 1'b1;
         else begin
            cnt <= FULL;
            n   <= n + 4'd1;
            if (n == 4'd0)
               active <= ~sync[1];
            else if (n < 4'd9)
               sh <= {sync[1], sh[7:1]};
            else begin
               active     <= 1'b0;
               data       <= sh;
               byte_valid <= sync[1];
               frame_err  <= ~sync[1];
            end
         end
      end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: frames A5 + DEPTH bytes from UART into program RAM, holding the CPU meanwhile
// UART_LOADER_CHECKSUM_EN adds a trailing 8-bit sum byte that must match the data bytes
module uart_prog_loader
   import loader_pkg::*;
#(
   parameter int CLK_HZ      = 24000000,
   parameter int BAUD        = 115200,
   parameter int DEPTH       = 16,
   parameter int TIMEOUT_CYC = 2400000,
   localparam int ADDR_W     = calc_addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rxd,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              load_done,
   output logic              load_err
);
   localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
   logic [7:0]        data;
   logic              byte_valid, frame_err;
   state_t            state, state_n;
   logic [ADDR_W-1:0] idx, idx_n, addr_n;
   logic [7:0]        sum, sum_n, wdata_n;
   logic [GAP_W-1:0]  gap, gap_n;
   logic              fin, fin_n, we_n, done_n, err_n, last;
   uart_rx_core #(.DIV(calc_div(CLK_HZ, BAUD))) u_rx (
      .clk(clk), .rst_n(rst_n), .rxd(rxd),
      .data(data), .byte_valid(byte_valid), .frame_err(frame_err)
   );
   assign busy     = state != IDLE;
   assign cpu_hold = busy;
   assign last     = idx == ADDR_W'(DEPTH - 1);
   // registered FSM state, datapath and one-cycle strobes
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         sum       <= '0;
         gap       <= '0;
         fin       <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         sum       <= sum_n;
         gap       <= gap_n;
         fin       <= fin_n;
         ram_we    <= we_n;
         ram_addr  <= addr_n;
         ram_wdata <= wdata_n;
         load_done <= done_n;
         load_err  <= err_n;
      end
   // framing: sync hunt, data writes, optional checksum, aborts on framing error or inter-byte gap
   always_comb begin
      state_n = state;
      idx_n   = idx;
      sum_n   = sum;
      gap_n   = gap + 1'b1;
      fin_n   = 1'b0;
      we_n    = 1'b0;
      addr_n  = ram_addr;
      wdata_n = ram_wdata;
      done_n  = 1'b0;
      err_n   = 1'b0;
      if (state == IDLE) begin
         gap_n = '0;
         if (byte_valid && data == SYNC_BYTE) begin
            state_n = DATA;
            idx_n   = '0;
            sum_n   = '0;
         end
      end else if (fin) begin
         state_n = IDLE;
         done_n  = 1'b1;
      end else if (frame_err || gap == GAP_W'(TIMEOUT_CYC)) begin
         state_n = IDLE;
         err_n   = 1'b1;
      end else if (byte_valid) begin
         gap_n = '0;
         if (state == DATA) begin
            we_n    = 1'b1;
            addr_n  = idx;
            wdata_n = data;
            sum_n   = sum + data;
            idx_n   = last ? idx : idx + 1'b1;
`ifdef UART_LOADER_CHECKSUM_EN
            state_n = last ? CHK : DATA;
`else
            fin_n   = last;
`endif
         end else begin
            state_n = IDLE;
            done_n  = data == sum;
            err_n   = data != sum;
         end
      end
   end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: table-driven frame vectors plus framing-error, timeout, checksum and reset sequences
module tb_uart_prog_loader;
   localparam int DIV     = 16;
   localparam int TIMEOUT = 2000;
   logic       clk = 1'b0, rst_n = 1'b0, rxd = 1'b1;
   logic       ram_we, cpu_hold, busy, load_done, load_err;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   int checks = 0, errors = 0;
   int cyc = 0, wr_cnt, done_cnt, err_cnt, seq_bad, both, last_we, done_at, err_at;
   logic       hold_at_done, hold_at_err;
   logic [7:0] got [16];
   typedef struct {
      logic [7:0] base;
      logic [7:0] step;
      bit         noise;
      int         exp_done;
      int         exp_err;
      int         exp_writes;
   } vec_t;
   vec_t vecs [5];
   uart_prog_loader #(.CLK_HZ(1600000), .BAUD(100000), .DEPTH(16), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .rxd(rxd), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .cpu_hold(cpu_hold), .busy(busy),
      .load_done(load_done), .load_err(load_err)
   );
   always #5 clk = ~clk;
   // cycle counter for latency measurements
   always @(posedge clk) cyc <= cyc + 1;
   // observe RAM writes and result pulses away from the active edge
   always @(negedge clk) begin
      if (ram_we) begin
         if (int'(ram_addr) != wr_cnt) seq_bad++;
         got[ram_addr] = ram_wdata;
         wr_cnt++;
         last_we = cyc;
      end
      if (load_done) begin done_cnt++; done_at = cyc; hold_at_done = cpu_hold; end
      if (load_err) begin err_cnt++; err_at = cyc; hold_at_err = cpu_hold; end
      if (load_done && load_err) both++;
   end
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic clear_mon();
      wr_cnt = 0; done_cnt = 0; err_cnt = 0; seq_bad = 0; both = 0;
      last_we = 0; done_at = 0; err_at = 0; hold_at_done = 1'b1; hold_at_err = 1'b1;
      for (int i = 0; i < 16; i++) got[i] = 8'h00;
   endtask
   task automatic send_byte(input logic [7:0] b, input bit stop);
      rxd = 1'b0;
      repeat (DIV) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (DIV) @(posedge clk);
      end
      rxd = stop;
      repeat (DIV) @(posedge clk);
      rxd = 1'b1;
      if (!stop) repeat (DIV) @(posedge clk);
   endtask
   task automatic send_frame(input logic [7:0] base, input logic [7:0] step, input bit noise, input bit bad_chk);
      logic [7:0] s;
      s = 8'h00;
      if (noise) begin send_byte(8'h3C, 1'b1); send_byte(8'hFF, 1'b1); end
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 16; i++) begin
         logic [7:0] d;
         d = base + step * 8'(i);
         s = s + d;
         send_byte(d, 1'b1);
      end
`ifdef UART_LOADER_CHECKSUM_EN
      send_byte(bad_chk ? 8'h00 : s, 1'b1);
`else
      if (bad_chk) s = 8'h00;
`endif
      repeat (30) @(posedge clk);
   endtask
   task automatic check_data(input string name, input logic [7:0] base, input logic [7:0] step, input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < n; i++) if (got[i] !== 8'(base + step * 8'(i))) bad++;
      check(name, bad, 0);
   endtask
   task automatic run_vec(input int k);
      clear_mon();
      send_frame(vecs[k].base, vecs[k].step, vecs[k].noise, 1'b0);
      check($sformatf("v%0d done", k), done_cnt, vecs[k].exp_done);
      check($sformatf("v%0d err", k), err_cnt, vecs[k].exp_err);
      check($sformatf("v%0d writes", k), wr_cnt, vecs[k].exp_writes);
      check($sformatf("v%0d addr_seq", k), seq_bad, 0);
      check_data($sformatf("v%0d data", k), vecs[k].base, vecs[k].step, 16);
      check($sformatf("v%0d hold_at_done", k), int'(hold_at_done), 0);
      check($sformatf("v%0d hold_after", k), int'(cpu_hold), 0);
      check($sformatf("v%0d busy_after", k), int'(busy), 0);
      check($sformatf("v%0d coincide", k), both, 0);
`ifndef UART_LOADER_CHECKSUM_EN
      check($sformatf("v%0d done_latency", k), done_at - last_we, 1);
`endif
   endtask
   initial begin
      vecs[0] = '{8'h00, 8'h01, 1'b0, 1, 0, 16};
      vecs[1] = '{8'h00, 8'h01, 1'b1, 1, 0, 16};
      vecs[2] = '{8'hFF, 8'h00, 1'b0, 1, 0, 16};
      vecs[3] = '{8'hA5, 8'h00, 1'b0, 1, 0, 16};
      vecs[4] = '{8'h80, 8'h11, 1'b0, 1, 0, 16};
      clear_mon();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", int'({ram_we, cpu_hold, busy, load_done, load_err, ram_addr, ram_wdata}), 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      for (int k = 0; k < 5; k++) run_vec(k);
      // stop bit low on data byte 5
      clear_mon();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b1);
      send_byte(8'h05, 1'b0);
      repeat (30) @(posedge clk);
      check("ferr err", err_cnt, 1);
      check("ferr done", done_cnt, 0);
      check("ferr writes", wr_cnt, 5);
      check_data("ferr data", 8'h00, 8'h01, 5);
      check("ferr hold_at_err", int'(hold_at_err), 0);
      check("ferr busy", int'(busy), 0);
      run_vec(0);
      // stall after data byte 7
      clear_mon();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1);
      repeat (TIMEOUT / 2) @(posedge clk);
      check("stall hold_mid", int'(cpu_hold), 1);
      repeat (TIMEOUT / 2 + 200) @(posedge clk);
      check("stall err", err_cnt, 1);
      check("stall writes", wr_cnt, 8);
      check("stall window", int'((err_at - last_we) >= TIMEOUT - 2 && (err_at - last_we) <= TIMEOUT + 3), 1);
      check("stall hold", int'(cpu_hold), 0);
      run_vec(4);
`ifdef UART_LOADER_CHECKSUM_EN
      clear_mon();
      send_frame(8'h00, 8'h01, 1'b0, 1'b1);
      check("badchk err", err_cnt, 1);
      check("badchk done", done_cnt, 0);
      check("badchk writes", wr_cnt, 16);
`endif
      // asynchronous reset in the middle of a frame
      clear_mon();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'(i), 1'b1);
      rxd = 1'b0;
      repeat (5) @(posedge clk);
      check("rst busy_before", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst async_outputs", int'({ram_we, cpu_hold, busy, load_done, load_err}), 0);
      rxd = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      run_vec(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
